// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: LSU-side controller for the single-port TCM SRAM.
// Turns a valid/ready load/store request into RAM addr/din/we/wem and returns
// aligned, sign/zero-extended read data on a valid/ready response channel.
// Optional feature macro: DTCM_CTRL_MISALIGN_CHK_EN (flags misaligned half/word
// accesses as errors; when undefined the misaligned low address bits are ignored).
module dtcm_ctrl #(
  parameter int unsigned RAM_DP = 512,
  parameter int unsigned RAM_AW = 9,
  parameter int unsigned AW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  input  logic [31:0]       ram_dout
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRsp  = 1'b1;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  logic [0:0]        state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              op_q, op_d;    // 1 = store
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;

  logic              accept;
  logic              range_err;
  logic              misalign_err;
  logic              req_err;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign rsp_valid = (state_q == StRsp);
  assign req_ready = !rst && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Any byte beyond the last RAM word is out of range.
  assign range_err = (req_addr >> 2) >= AW'(RAM_DP);

`ifdef DTCM_CTRL_MISALIGN_CHK_EN
  assign misalign_err = ((req_size == SzHalf) && req_addr[0]) ||
                        ((req_size == SzWord) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_err = 1'b0;
`endif

  assign req_err = range_err || (req_size == 2'b11) || misalign_err;

  assign ram_we   = accept && req_wen && !req_err;
  // Outside accept cycles the held address makes the RAM re-read the same word,
  // keeping ram_dout stable while the response is stalled.
  assign ram_addr = accept ? req_addr[RAM_AW+1:2] : addr_q;

  // Store lane steering: replicate data, mask selects the lanes written.
  always_comb begin
    ram_wem = 4'b0000;
    ram_din = 32'h0;
    unique case (req_size)
      SzByte: begin
        ram_wem = 4'b0001 << req_addr[1:0];
        ram_din = {4{req_wdata[7:0]}};
      end
      SzHalf: begin
        ram_wem = req_addr[1] ? 4'b1100 : 4'b0011;
        ram_din = {2{req_wdata[15:0]}};
      end
      SzWord: begin
        ram_wem = 4'b1111;
        ram_din = req_wdata;
      end
      default: begin
        ram_wem = 4'b0000;
        ram_din = 32'h0;
      end
    endcase
  end

  // Next-state: response bookkeeping reloads on every accept.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    size_d  = size_q;
    lane_d  = lane_q;
    uns_d   = uns_q;
    err_d   = err_q;
    if (accept) begin
      state_d = StRsp;
      addr_d  = req_addr[RAM_AW+1:2];
      op_d    = req_wen;
      size_d  = req_size;
      lane_d  = req_addr[1:0];
      uns_d   = req_unsigned;
      err_d   = req_err;
    end else if (rsp_ready) begin
      state_d = StIdle;
    end
  end

  // State registers with synchronous reset; a pending response is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      op_q    <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  // Read data alignment and extension, straight from the RAM output.
  always_comb begin
    unique case (lane_q)
      2'd0:    byte_sel = ram_dout[7:0];
      2'd1:    byte_sel = ram_dout[15:8];
      2'd2:    byte_sel = ram_dout[23:16];
      default: byte_sel = ram_dout[31:24];
    endcase
    half_sel = lane_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    unique case (size_q)
      SzByte:  rsp_rdata = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      SzHalf:  rsp_rdata = {{16{half_sel[15] & ~uns_q}}, half_sel};
      SzWord:  rsp_rdata = ram_dout;
      default: rsp_rdata = 32'h0;
    endcase
    if (op_q || err_q) begin
      rsp_rdata = 32'h0;
    end
  end

  assign rsp_err = rsp_valid && err_q;

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Testbench for dtcm_ctrl: directed scenarios followed by random traffic,
// checked against a byte-array memory model and a one-slot response model.
module tb_dtcm_ctrl;

  localparam int unsigned RAM_DP = 512;
  localparam int unsigned RAM_AW = 9;
  localparam int unsigned AW     = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic              req_wen = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [3:0]        ram_wem;
  logic [31:0]       ram_dout;

  logic              mem_clr = 1'b1;
  logic [31:0]       ram [RAM_DP];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [7:0]  ref_mem [RAM_DP*4];
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  logic [31:0] m_idx   = '0;

  dtcm_ctrl #(
    .RAM_DP (RAM_DP),
    .RAM_AW (RAM_AW),
    .AW     (AW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_wem      (ram_wem),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM: byte-masked write, registered read when we=0.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(RAM_DP); i++) ram[i] <= 32'h0;
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_wem[i]) ram[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      end
    end else begin
      ram_dout <= ram[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
    logic e;
    e = (a >= RAM_DP * 4) || (sz == 2'b11);
`ifdef DTCM_CTRL_MISALIGN_CHK_EN
    if (sz == 2'b01 && (a % 2) != 0) e = 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic u);
    logic [31:0] v;
    int unsigned base;
    case (sz)
      2'b00: begin
        v = {24'h0, ref_mem[a]};
        if (!u && v >= 32'h80) v = v - 32'h100;
      end
      2'b01: begin
        base = a & ~32'h1;
        v = {16'h0, ref_mem[base+1], ref_mem[base]};
        if (!u && v >= 32'h8000) v = v - 32'h10000;
      end
      2'b10: begin
        base = a & ~32'h3;
        v = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned base;
    case (sz)
      2'b00: ref_mem[a] = wd[7:0];
      2'b01: begin
        base = a & ~32'h1;
        ref_mem[base]   = wd[7:0];
        ref_mem[base+1] = wd[15:8];
      end
      2'b10: begin
        base = a & ~32'h3;
        for (int i = 0; i < 4; i++) ref_mem[base+i] = wd[8*i +: 8];
      end
      default: ;
    endcase
  endtask

  function automatic logic [3:0] model_wem(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001 << (a % 4);
      2'b01:   return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_din(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // One clock: drive at negedge, check #1 later, advance the model at posedge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] a, input logic w,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd,
                       input logic rr);
    logic        exp_ready, acc, e_err;
    logic [31:0] idx;
    @(negedge clk);
    rst = r; req_valid = v; req_addr = a; req_wen = w; req_size = sz;
    req_unsigned = u; req_wdata = wd; rsp_ready = rr;
    #1;
    exp_ready = !r && (!m_valid || rr);
    acc       = v && exp_ready;
    e_err     = model_err(a, sz);
    idx       = (a >> 2) % RAM_DP;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("rsp_rdata", rsp_rdata, m_rdata);
      check_eq("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    check_eq("ram_we", 32'(ram_we), 32'(acc && w && !e_err));
    if (acc && w && !e_err) begin
      check_eq("ram_wem", 32'(ram_wem), 32'(model_wem(a, sz)));
      check_eq("ram_din", ram_din, model_din(sz, wd));
    end
    if (acc) check_eq("ram_addr_acc", 32'(ram_addr), idx);
    else if (!r) check_eq("ram_addr_hold", 32'(ram_addr), m_idx);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_idx   = 32'h0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_err   = e_err;
      m_idx   = idx;
      if (w) begin
        if (!e_err) model_store(a, sz, wd);
        m_rdata = 32'h0;
      end else begin
        m_rdata = e_err ? 32'h0 : model_load(a, sz, u);
      end
    end else if (rr) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, rr);
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    cycle(1'b0, 1'b1, a, 1'b1, sz, 1'b0, wd, 1'b1);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic rr);
    cycle(1'b0, 1'b1, a, 1'b0, sz, u, 32'h0, rr);
  endtask

  initial begin
    logic        r, v, w, u, rr;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int unsigned sel;

    for (int i = 0; i < int'(RAM_DP * 4); i++) ref_mem[i] = 8'h0;

    // Reset, memory cleared
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    mem_clr = 1'b0;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1);
    idle(1'b1);

    // Word store then load
    st(32'h4, 2'b10, 32'h1234_5678);
    ld(32'h4, 2'b10, 1'b0, 1'b1);
    idle(1'b1);

    // Sign/zero extension
    st(32'h4, 2'b10, 32'h8000_00F0);
    ld(32'h4, 2'b00, 1'b0, 1'b1);
    ld(32'h4, 2'b00, 1'b1, 1'b1);
    ld(32'h6, 2'b01, 1'b0, 1'b1);
    ld(32'h6, 2'b01, 1'b1, 1'b1);
    idle(1'b1);

    // Byte store into a lane, then readback
    st(32'h4, 2'b10, 32'h1234_5678);
    st(32'h6, 2'b00, 32'h0000_00AB);
    ld(32'h4, 2'b10, 1'b0, 1'b1);
    idle(1'b1);
    check_eq("sb_merge", {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}, 32'h12AB_5678);

    // Back-pressure with a waiting request
    st(32'h8, 2'b10, 32'hCAFE_F00D);
    ld(32'h4, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) ld(32'h8, 2'b10, 1'b0, 1'b0);
    ld(32'h8, 2'b10, 1'b0, 1'b1);
    idle(1'b1);

    // Out-of-range store must not touch memory
    st(32'h800, 2'b10, 32'hDEAD_BEEF);
    idle(1'b1);

    // Misaligned word load
    ld(32'h5, 2'b10, 1'b0, 1'b1);
    idle(1'b1);

    // Reset while a response is stalled
    ld(32'h4, 2'b10, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b1, 32'h8, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'h800 + 32'($urandom_range(0, 15));
      else               a = 32'($urandom_range(0, 63));
      w   = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      u   = 1'($urandom_range(0, 1));
      wd  = $urandom;
      rr  = ($urandom_range(0, 3) != 0);
      cycle(r, v, a, w, sz, u, wd, rr);
    end
    idle(1'b1);
    idle(1'b1);

    // RAM contents against the model
    for (int i = 0; i < 32; i++) begin
      check_eq("mem_word", ram[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtcm_ctrl.md
# dtcm_ctrl

Initiator-side controller for the single-port synchronous SRAM (`sim_ram`) used as ITCM/DTCM. Converts the LSU's valid/ready load/store request into RAM `addr`/`din`/`we`/`wem` with byte-lane masks. Returns aligned, sign- or zero-extended read data over a valid/ready response channel. While the response is back-pressured it holds the RAM read address so RAM output stays stable.

## Interface
Parameters:
- `RAM_DP`, 512, RAM depth in 32-bit words
- `RAM_AW`, 9, RAM word-address width; must equal clog2(`RAM_DP`)
- `AW`, 32, request byte-address width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a rising edge
- `req_addr`  in  AW  byte address
- `req_wen`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `req_unsigned`  in  1  load zero-extend (LBU/LHU)
- `req_wdata`  in  32  store data, right-aligned
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`
- `rsp_rdata`  out  32  load result; 0 for stores and errors
- `rsp_err`  out  1  access error; no RAM write performed
- `ram_addr`  out  RAM_AW  RAM word address
- `ram_din`  out  32  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_wem`  out  4  RAM byte write mask
- `ram_dout`  in  32  RAM read data; valid the cycle after the address is sampled with `we`=0

## Operation
- Handshake:
  - `req_ready = !rst && (!rsp_valid || rsp_ready)`.
  - Accept = `req_valid && req_ready`.
  - At most one response outstanding.
- Word index: `req_addr[RAM_AW+1:2]`. Error if `req_addr[AW-1:RAM_AW+2]` ≠ 0, or if `req_size` = 11.
- Store lanes:
  - Byte: `wem = 1<<addr[1:0]`, `din = {4{wdata[7:0]}}`.
  - Half: `wem = addr[1] ? 1100 : 0011`, `din = {2{wdata[15:0]}}`.
  - Word: `wem = 1111`, `din = wdata`.
- `ram_we = accept && req_wen && !err`. `ram_din`/`ram_wem` are don't-care when `ram_we` = 0.
- `ram_addr` selection:
  - Accept cycle: combinationally the request word index.
  - Otherwise: registered `addr_q`, loaded on every accept. `ram_we` = 0 in those cycles, so the RAM resamples the same address and `ram_dout` stays stable during stalls.
- Registered per accept: `op_q` (read/write), `size_q`, `lane_q = addr[1:0]`, `uns_q`, `err_q`.
- States:
  - IDLE: `rsp_valid` = 0.
  - RSP: `rsp_valid` = 1.
  - IDLE→RSP on accept.
  - RSP→IDLE on `rsp_ready` without a new accept.
  - RSP→RSP on `rsp_ready` with a back-to-back accept.
- Read data (combinational from `ram_dout`):
  - Byte: `ram_dout[8*lane+:8]`.
  - Half: `ram_dout[16*lane[1]+:16]`.
  - Word: `ram_dout`.
  - Sign-extended unless `uns_q`.
  - Forced to 0 when `op_q` = write or `err_q`.
- Reset:
  - Outputs: `rsp_valid`=0, `rsp_err`=0, `req_ready`=0, `ram_we`=0, `addr_q`=0.
  - State returns to IDLE.
  - A pending response is dropped. A mid-stall reset discards it without handshake.

## Timing
- Load accepted at edge N: `rsp_valid` and `rsp_rdata` valid after edge N (latency 1). Held until `rsp_ready`.
- Store accepted at edge N: RAM written at edge N, `rsp_valid` after edge N.
- Throughput: one request/cycle when `rsp_ready` is held 1.
- A store followed back-to-back by a load of the same word returns the new data.
- Simultaneous response consume and new accept in one cycle: response registers reload and `rsp_valid` stays 1.

## Configuration
- `DTCM_CTRL_MISALIGN_CHK_EN`:
  - Defined: half with `addr[0]`=1 or word with `addr[1:0]`≠0 sets `rsp_err`, suppresses the write, and returns 0.
  - Undefined: misaligned low bits are ignored. Half uses `addr[1]` only; word ignores `addr[1:0]`; no error is raised.

## Test plan
- Store word 0x1234_5678 at 0x4, then LW 0x4 → `rsp_rdata` 0x1234_5678, `rsp_err` 0, one cycle after accept.
- Word 1 = 0x8000_00F0:
  - LB 0x4 → 0xFFFF_FFF0
  - LBU 0x4 → 0x0000_00F0
  - LH 0x6 → 0xFFFF_8000
  - LHU 0x6 → 0x0000_8000
- Word 1 = 0x1234_5678; SB 0xAB to 0x6 → `ram_wem` 0100, `ram_din` 0xABAB_ABAB. Then LW 0x4 → 0x12AB_5678.
- LW 0x4 with `rsp_ready` = 0 for 5 cycles, `req_valid` held with LW 0x8 → `req_ready` stays 0, `ram_addr` stays 1, `rsp_rdata` stable. On release the second response returns word 2 the next cycle.
- `RAM_DP`=512, SW to 0x800 → `rsp_err` 1, `ram_we` never asserted, memory unchanged.
- LW 0x5:
  - With `DTCM_CTRL_MISALIGN_CHK_EN` → `rsp_err` 1, data 0.
  - Without → word 1 returned, `rsp_err` 0.
- Assert `rst` while a response is stalled → `rsp_valid` 0 the next cycle, `req_ready` 0 during reset.
